// File: rtl/instr_register_ctrl.sv
// Front-end for instr_register: arbitrates two writers onto the load port and makes it a shared instruction queue.
// Grant to rd_valid is 2 cycles; ready is withheld while full or flush; IRC_FIXED_PRIO_EN selects fixed req0 priority.
module instr_register_ctrl #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH),
  parameter int OPW   = 32,
  parameter int OPCW  = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPCW-1:0] req0_opcode,
  input  logic [OPW-1:0]  req0_op_a,
  input  logic [OPW-1:0]  req0_op_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPCW-1:0] req1_opcode,
  input  logic [OPW-1:0]  req1_op_a,
  input  logic [OPW-1:0]  req1_op_b,
  input  logic            flush,
  output logic            load_en,
  output logic [AW-1:0]   write_pointer,
  output logic [AW-1:0]   read_pointer,
  output logic [OPCW-1:0] opcode,
  output logic [OPW-1:0]  operand_a,
  output logic [OPW-1:0]  operand_b,
  output logic            rd_valid,
  input  logic            rd_pop,
  output logic [AW:0]     fill,
  output logic            full,
  output logic            empty
);

  typedef struct packed {
    logic [OPCW-1:0] opc;
    logic [OPW-1:0]  op_a;
    logic [OPW-1:0]  op_b;
  } instr_t;

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  instr_t        req0_dat;
  instr_t        req1_dat;
  instr_t        win_dat;
  logic [AW-1:0] alloc_ptr;
  logic          elig0;
  logic          elig1;
  logic          gnt0;
  logic          gnt1;
  logic          grant;
  logic          pop_ok;

  assign req0_dat = {req0_opcode, req0_op_a, req0_op_b};
  assign req1_dat = {req1_opcode, req1_op_a, req1_op_b};

  // The in-flight write already owns a slot, so it counts toward full.
  assign full     = (fill + {{AW{1'b0}}, load_en}) == FULL_CNT;
  assign empty    = (fill == '0);
  assign rd_valid = !empty;
  assign pop_ok   = rd_pop && rd_valid;

  assign elig0 = req0_valid && !full && !flush;
  assign elig1 = req1_valid && !full && !flush;

`ifdef IRC_FIXED_PRIO_EN
  assign gnt0 = elig0;
`else
  logic last_grant;  // 1: req1 was granted most recently

  assign gnt0 = elig0 && (!elig1 || last_grant);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (gnt0) begin
      last_grant <= 1'b0;
    end else if (gnt1) begin
      last_grant <= 1'b1;
    end
  end
`endif

  assign gnt1       = elig1 && !gnt0;
  assign grant      = gnt0 || gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign win_dat    = gnt1 ? req1_dat : req0_dat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_en       <= 1'b0;
      alloc_ptr     <= '0;
      write_pointer <= '0;
      read_pointer  <= '0;
      opcode        <= '0;
      operand_a     <= '0;
      operand_b     <= '0;
      fill          <= '0;
    end else if (flush) begin
      // Cancels the in-flight load; payload registers are left as they are.
      load_en       <= 1'b0;
      alloc_ptr     <= '0;
      write_pointer <= '0;
      read_pointer  <= '0;
      fill          <= '0;
    end else begin
      load_en <= grant;
      if (grant) begin
        write_pointer <= alloc_ptr;
        alloc_ptr     <= alloc_ptr + AW'(1);
        opcode        <= win_dat.opc;
        operand_a     <= win_dat.op_a;
        operand_b     <= win_dat.op_b;
      end
      if (pop_ok) begin
        read_pointer <= read_pointer + AW'(1);
      end
      fill <= fill + {{AW{1'b0}}, load_en} - {{AW{1'b0}}, pop_ok};
    end
  end

endmodule
